// File: rtl/cpu_run_pkg.sv
// Shared types and helpers for the Hack CPU run controller.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_e;

  localparam int unsigned MAX_CYCLES_DEF = 32'd3276800;
  localparam int unsigned HALT_HITS_DEF  = 32'd3;

  // An A-instruction at address k loading the value k: the "(END) @END" idiom.
  function automatic logic self_addressed(input logic [15:0] pc, input logic [15:0] instr);
    return !instr[15] && !pc[15] && (instr[14:0] == pc[14:0]);
  endfunction

endpackage

// File: rtl/cpu_halt_detector.sv
// Counts repeated fetches of one self-addressed A-instruction and flags a halt.
module cpu_halt_detector
  import cpu_run_pkg::*;
#(
  parameter int unsigned HALT_HITS = HALT_HITS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] pc,
  input  logic [15:0] instruct,
  output logic        halt,
  output logic [14:0] loop_pc
);

  localparam int unsigned HIT_W = $clog2(HALT_HITS + 1);

  logic [HIT_W-1:0] hits_q, hits_d;
  logic [14:0]      loop_pc_q, loop_pc_d;
  logic             fetch_self;

  always_comb begin
    fetch_self = self_addressed(pc, instruct);
    hits_d     = hits_q;
    loop_pc_d  = loop_pc_q;
    if (clear) begin
      hits_d    = '0;
      loop_pc_d = '0;
    end else if (enable && fetch_self) begin
      // The loop's jump word is not self-addressed, so it never disturbs the count.
      if ((pc[14:0] == loop_pc_q) && (hits_q != '0)) begin
        hits_d = hits_q + HIT_W'(1);
      end else begin
        hits_d    = HIT_W'(1);
        loop_pc_d = pc[14:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q    <= '0;
      loop_pc_q <= '0;
    end else begin
      hits_q    <= hits_d;
      loop_pc_q <= loop_pc_d;
    end
  end

  assign halt    = enable && fetch_self && (hits_d == HIT_W'(HALT_HITS));
  assign loop_pc = loop_pc_d;

endmodule

// File: rtl/cpu_run_controller.sv
// Sequences one Hack CPU run: reset pulse, cycle counting, halt/timeout
// detection and RAM write gating.
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned HALT_HITS  = HALT_HITS_DEF,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      pc,
  input  logic [15:0]      instruct,
  input  logic             writeM,
  output logic             cpu_reset,
  output logic             ram_we,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [14:0]      halt_pc,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("cpu_run_controller: RST_CYCLES must be at least 1");
  end
  if ((CNT_W < 64) && (64'(MAX_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_cnt_w
    $error("cpu_run_controller: MAX_CYCLES does not fit in CNT_W bits");
  end

  run_state_e       state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             halted_q, halted_d;
  logic             timeout_q, timeout_d;
  logic [14:0]      halt_pc_q, halt_pc_d;
  logic             det_clear, det_enable, det_halt;
  logic [14:0]      det_loop_pc;

  cpu_halt_detector #(
    .HALT_HITS (HALT_HITS)
  ) u_halt_det (
    .clk      (clk),
    .reset    (reset),
    .clear    (det_clear),
    .enable   (det_enable),
    .pc       (pc),
    .instruct (instruct),
    .halt     (det_halt),
    .loop_pc  (det_loop_pc)
  );

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    cnt_d      = cnt_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    halt_pc_d  = halt_pc_q;
    det_clear  = 1'b0;
    det_enable = (state_q == RUN);
    cnt_inc    = cnt_q + CNT_W'(1);

    cpu_reset  = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    ram_we     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          state_d   = RST;
          det_clear = 1'b1;
          cnt_d     = '0;
          halted_d  = 1'b0;
          timeout_d = 1'b0;
          halt_pc_d = '0;
          rst_cnt_d = RC_W'(RST_CYCLES - 1);
        end
      end
      RST: begin
        busy = 1'b1;
        if (rst_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RC_W'(1);
        end
      end
      RUN: begin
        busy      = 1'b1;
        cpu_reset = 1'b0;
        ram_we    = writeM;
        cnt_d     = cnt_inc;
        // A halt on the timeout cycle takes precedence.
        if (det_halt) begin
          state_d   = DONE;
          halted_d  = 1'b1;
          halt_pc_d = det_loop_pc;
        end else if (cnt_inc == CNT_W'(MAX_CYCLES)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      halt_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      halt_pc_q <= halt_pc_d;
    end
  end

  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign halt_pc     = halt_pc_q;
  assign cycle_count = cnt_q;

endmodule
